// File: rtl/mul32_seq_pkg.sv
// Shared definitions for the sequential 32x32 shift-add multiplier: state
// encodings, sizes, result-mux opcode and the two's-complement helpers.
package mul32_seq_pkg;

  localparam int WIDTH    = 32;
  localparam int MUL_ITER = 32;
  localparam int COUNT_W  = 5;

  localparam logic [COUNT_W-1:0] COUNT_LAST = 5'(MUL_ITER - 1);

  // Selects the multiplier's product_lo on the ALU 4:1 result mux.
  localparam logic [1:0] ALU_OP_MUL = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // ~v + cin; cin=1 gives the 32-bit two's-complement negation.
  function automatic logic [WIDTH-1:0] neg32(input logic [WIDTH-1:0] v, input logic cin);
    return ~v + {{(WIDTH-1){1'b0}}, cin};
  endfunction

  // Operand magnitude; 0x8000_0000 maps to 2^31, which is still a valid unsigned value.
  function automatic logic [WIDTH-1:0] mag32(input logic [WIDTH-1:0] v, input logic is_signed);
    logic [WIDTH-1:0] m;
    if (is_signed && v[WIDTH-1]) begin
      m = neg32(v, 1'b1);
    end else begin
      m = v;
    end
    return m;
  endfunction

endpackage

// File: rtl/mul32_seq_if.sv
// Request/result bundle between the ALU sequencer (master) and mul32_seq (slave).
interface mul32_seq_if;
  import mul32_seq_pkg::*;

  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product_lo;
  logic [WIDTH-1:0] product_hi;
  logic             ovf;

  modport master (
    output start, signed_op, a, b,
    input  busy, done, product_lo, product_hi, ovf
  );

  modport slave (
    input  start, signed_op, a, b,
    output busy, done, product_lo, product_hi, ovf
  );

endinterface

// File: rtl/mul32_seq_negate64.sv
// Combinational 64-bit two's-complement negate; the upper half takes the
// carry out of the lower half, which is only set when the lower half is zero.
module negate64
  import mul32_seq_pkg::*;
(
  input  logic [2*WIDTH-1:0] value,
  output logic [2*WIDTH-1:0] result
);

  logic lo_zero;

  assign lo_zero = (value[WIDTH-1:0] == 32'd0);
  assign result  = {neg32(value[2*WIDTH-1:WIDTH], lo_zero), neg32(value[WIDTH-1:0], 1'b1)};

endmodule

// File: rtl/mul32_seq.sv
// Sequential 32x32 shift-add multiplier: magnitudes are multiplied over 32
// clocks, the sign is applied in FIN and the product/ovf registers are loaded.
module mul32_seq
  import mul32_seq_pkg::*;
(
  input logic         clk,
  input logic         rst,
  mul32_seq_if.slave  bus
);

  state_t               state_r;
  state_t               state_s;
  logic [COUNT_W-1:0]   count_r;
  logic [2*WIDTH-1:0]   acc_r;
  logic [WIDTH:0]       mcand_r;
  logic [WIDTH-1:0]     mplier_r;
  logic                 neg_r;
  logic                 sign_r;
  logic                 done_r;
  logic                 ovf_r;
  logic [WIDTH-1:0]     prod_hi_r;
  logic [WIDTH-1:0]     prod_lo_r;

  logic [WIDTH:0]       sum_s;
  logic [2*WIDTH-1:0]   neg_acc_s;
  logic [2*WIDTH-1:0]   result_s;
  logic                 ovf_s;

  negate64 u_negate64 (
    .value  (acc_r),
    .result (neg_acc_s)
  );

  // Partial-product add into the upper half, then sign fix-up and overflow flag.
  always_comb begin
    sum_s    = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
    result_s = acc_r;
    ovf_s    = 1'b0;
    if (mplier_r[0]) begin
      sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + mcand_r;
    end else begin
      sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
    end
    if (neg_r) begin
      result_s = neg_acc_s;
    end else begin
      result_s = acc_r;
    end
    if (sign_r) begin
      ovf_s = (result_s[2*WIDTH-1:WIDTH] != {WIDTH{result_s[WIDTH-1]}});
    end else begin
      ovf_s = (result_s[2*WIDTH-1:WIDTH] != 32'd0);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) state_s = RUN;
        else           state_s = IDLE;
      end
      RUN: begin
        if (count_r == COUNT_LAST) state_s = FIN;
        else                       state_s = RUN;
      end
      FIN:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Operand latch, shift-add iteration and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r   <= 5'd0;
      acc_r     <= 64'd0;
      mcand_r   <= 33'd0;
      mplier_r  <= 32'd0;
      neg_r     <= 1'b0;
      sign_r    <= 1'b0;
      done_r    <= 1'b0;
      ovf_r     <= 1'b0;
      prod_hi_r <= 32'd0;
      prod_lo_r <= 32'd0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            mcand_r  <= {1'b0, mag32(bus.a, bus.signed_op)};
            mplier_r <= mag32(bus.b, bus.signed_op);
            neg_r    <= bus.signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            sign_r   <= bus.signed_op;
            acc_r    <= 64'd0;
            count_r  <= 5'd0;
          end
        end
        RUN: begin
          acc_r    <= {sum_s, acc_r[WIDTH-1:1]};
          mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
          count_r  <= count_r + 5'd1;
        end
        FIN: begin
          prod_hi_r <= result_s[2*WIDTH-1:WIDTH];
          prod_lo_r <= result_s[WIDTH-1:0];
          ovf_r     <= ovf_s;
          done_r    <= 1'b1;
        end
        default: begin
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = (state_r != IDLE);
  assign bus.done       = done_r;
  assign bus.product_hi = prod_hi_r;
  assign bus.product_lo = prod_lo_r;
  assign bus.ovf        = ovf_r;

endmodule

// File: tb/tb_mul32_seq.sv
// Directed bench for mul32_seq: expected products come from a behavioural
// model pushed to a scoreboard at start and popped when done pulses.
module tb_mul32_seq;
  import mul32_seq_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   busy_cnt = 0;
  logic [31:0] prev_hi = 32'd0;
  logic [31:0] prev_lo = 32'd0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  mul32_seq_if bus ();

  mul32_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic exp_t model(input logic sg, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    exp_t e;
    if (sg) p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    else    p = {32'd0, a} * {32'd0, b};
    e.hi  = p[63:32];
    e.lo  = p[31:0];
    e.ovf = sg ? (p[63:32] !== {32{p[31]}}) : (p[63:32] !== 32'd0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at #1 after a rising edge; start is sampled on the next edge.
  task automatic start_op(input logic sg, input logic [31:0] a, input logic [31:0] b, input bit push);
    bus.signed_op = sg;
    bus.a         = a;
    bus.b         = b;
    bus.start     = 1'b1;
    if (push) sbq.push_back(model(sg, a, b));
    @(posedge clk); #1;
    bus.start = 1'b0;
    busy_cnt  = (bus.busy === 1'b1) ? 1 : 0;
  endtask

  task automatic run_and_check(input string tag, input int inject_at);
    int   n;
    exp_t e;
    n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (bus.busy === 1'b1) busy_cnt++;
      if (n == inject_at) begin
        bus.start     = 1'b1;
        bus.signed_op = 1'b0;
        bus.a         = 32'hDEAD_BEEF;
        bus.b         = 32'h0000_1234;
      end else begin
        bus.start = 1'b0;
      end
      if (n == 16) begin
        chk({tag, "_hold_hi"}, 64'(bus.product_hi), 64'(prev_hi));
        chk({tag, "_hold_lo"}, 64'(bus.product_lo), 64'(prev_lo));
      end
    end
    chk({tag, "_latency"}, 64'(n), 64'd33);
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (bus.done === 1'b1) begin
        chk({tag, "_hi"}, 64'(bus.product_hi), 64'(e.hi));
        chk({tag, "_lo"}, 64'(bus.product_lo), 64'(e.lo));
        chk({tag, "_ovf"}, 64'(bus.ovf), 64'(e.ovf));
      end
      prev_hi = e.hi;
      prev_lo = e.lo;
    end
  endtask

  initial begin
    int dones;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.signed_op = 1'b0;
    bus.a         = 32'd0;
    bus.b         = 32'd0;
    $display("multiply result-mux opcode %0d", ALU_OP_MUL);
    #12;
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_ovf", 64'(bus.ovf), 64'd0);
    chk("reset_prod", {bus.product_hi, bus.product_lo}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    start_op(1'b0, 32'd7, 32'd6, 1'b1);
    run_and_check("u7x6", -1);
    @(posedge clk); #1;
    chk("done_one_cycle", 64'(bus.done), 64'd0);

    start_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    run_and_check("u_max", -1);
    start_op(1'b1, 32'hFFFF_FFFD, 32'd5, 1'b1);
    run_and_check("s_m3x5", -1);
    start_op(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1);
    run_and_check("s_min", -1);
    start_op(1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
    run_and_check("s_maxmin", -1);
    start_op(1'b0, 32'd0, 32'hFFFF_FFFF, 1'b1);
    run_and_check("u_zero", -1);

    for (int i = 0; i < 5; i++) begin
      start_op(1'($urandom_range(0, 1)), $urandom, $urandom, 1'b1);
      run_and_check("rand", -1);
    end

    // Start mid-RUN is ignored; start in the done cycle is accepted.
    start_op(1'b0, 32'd9, 32'd11, 1'b1);
    run_and_check("ignore_mid", 10);
    start_op(1'b1, 32'h1234_5678, 32'hFFFF_FFFE, 1'b1);
    run_and_check("b2b", -1);

    // Reset in the middle of RUN aborts with no done pulse.
    start_op(1'b0, 32'h0000_1234, 32'h0000_5678, 1'b0);
    repeat (15) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_ovf", 64'(bus.ovf), 64'd0);
    chk("abort_prod", {bus.product_hi, bus.product_lo}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    prev_hi = 32'd0;
    prev_lo = 32'd0;
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) dones++;
    end
    chk("abort_no_done", 64'(dones), 64'd0);
    start_op(1'b0, 32'd2, 32'd3, 1'b1);
    run_and_check("after_abort", -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
